// File: rtl/mux2_pkg.sv
// mux2_pkg: shared defaults and FSM state encoding for the two-channel round-robin arbiter.
`default_nettype none

package mux2_pkg;

  localparam int DW_DEFAULT    = 1;
  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way round-robin pick; a tie goes to the channel
// that did not win last time.
`default_nettype none

module rr_pick2 (
  input  logic v0,
  input  logic v1,
  input  logic last_gnt,
  input  logic en,
  output logic gnt0,
  output logic gnt1,
  output logic gnt_idx
);

  always_comb begin
    gnt0    = en && v0 && (!v1 || last_gnt);
    gnt1    = en && v1 && (!v0 || !last_gnt);
    gnt_idx = gnt1;
  end

endmodule

`default_nettype wire

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: two-channel round-robin arbiter with a single registered output stage.
// Optional per-channel saturating grant counters are enabled with GRANT_CNT_EN.
`default_nettype none

module mux2_rr_arbiter
  import mux2_pkg::*;
#(
  parameter int DW = DW_DEFAULT
`ifdef GRANT_CNT_EN
  ,
  parameter int CNT_W = CNT_W_DEFAULT
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in0_valid,
  input  logic [DW-1:0] in0_data,
  output logic          in0_ready,
  input  logic          in1_valid,
  input  logic [DW-1:0] in1_data,
  output logic          in1_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_sel
`ifdef GRANT_CNT_EN
  ,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
`endif
);

  state_t state;
  logic   last_gnt;
  logic   load_en;
  logic   gnt0;
  logic   gnt1;
  logic   gnt_idx;
  logic   grant;

  assign out_valid = (state == ST_FULL);
  // The stage can take a new beat when empty or when the held one leaves this cycle.
  assign load_en   = !out_valid || out_ready;
  assign grant     = gnt0 || gnt1;
  assign in0_ready = gnt0;
  assign in1_ready = gnt1;

  rr_pick2 u_pick (
    .v0      (in0_valid),
    .v1      (in1_valid),
    .last_gnt(last_gnt),
    .en      (load_en),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .gnt_idx (gnt_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      out_data <= '0;
      out_sel  <= 1'b0;
      last_gnt <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (grant) begin
            state <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (!grant && out_ready) begin
            state <= ST_EMPTY;
          end
        end
        default: state <= ST_EMPTY;
      endcase
      if (grant) begin
        out_data <= gnt_idx ? in1_data : in0_data;
        out_sel  <= gnt_idx;
        last_gnt <= gnt_idx;
      end
    end
  end

`ifdef GRANT_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (gnt0 && (gnt_cnt0 != CNT_MAX)) begin
        gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
      end
      if (gnt1 && (gnt_cnt1 != CNT_MAX)) begin
        gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter: vector table, hand-written corner sequences and a randomized
// run against a reference model of the arbitration rules.
`default_nettype none

module tb_mux2_rr_arbiter;

  localparam int DW = 4;
`ifdef GRANT_CNT_EN
  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in0_valid, in1_valid;
  logic [DW-1:0] in0_data, in1_data;
  logic          in0_ready, in1_ready;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic          out_sel;
`ifdef GRANT_CNT_EN
  logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int m_valid, m_sel, m_data, m_last;
  int m_cnt[2];

  always #5 clk = ~clk;

  mux2_rr_arbiter #(
    .DW(DW)
`ifdef GRANT_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in0_valid(in0_valid),
    .in0_data (in0_data),
    .in0_ready(in0_ready),
    .in1_valid(in1_valid),
    .in1_data (in1_data),
    .in1_ready(in1_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sel  (out_sel)
`ifdef GRANT_CNT_EN
    , .gnt_cnt0(gnt_cnt0)
    , .gnt_cnt1(gnt_cnt1)
`endif
  );

  typedef struct {
    logic          v0, v1;
    logic [DW-1:0] d0, d1;
    logic          ordy;
    logic          er0, er1;
    logic          ev, esel;
    logic [DW-1:0] edata;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, input logic v1, input logic [DW-1:0] d0,
                       input logic [DW-1:0] d1, input logic ordy);
    in0_valid = v0;
    in1_valid = v1;
    in0_data  = d0;
    in1_data  = d1;
    out_ready = ordy;
  endtask

  // Leaves the bench at posedge+1 with rst_n released.
  task automatic do_reset();
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic v0, input logic v1, input int d0, input int d1,
                              input logic ordy, input logic er0, input logic er1,
                              input logic ev, input logic esel, input int edata);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.d0 = DW'(d0); v.d1 = DW'(d1); v.ordy = ordy;
    v.er0 = er0; v.er1 = er1; v.ev = ev; v.esel = esel; v.edata = DW'(edata);
    return v;
  endfunction

  // One randomized cycle checked against the arbitration rules.
  task automatic rand_cycle();
    logic v0, v1, ordy;
    logic [DW-1:0] d0, d1;
    int win;
    v0   = 1'($urandom_range(0, 1));
    v1   = 1'($urandom_range(0, 1));
    ordy = ($urandom_range(0, 3) != 0);
    d0   = DW'($urandom);
    d1   = DW'($urandom);
    win  = -1;
    if (!m_valid || ordy) begin
      if (v0 && v1) win = 1 - m_last;
      else if (v0)  win = 0;
      else if (v1)  win = 1;
    end
    drive(v0, v1, d0, d1, ordy);
    #1;
    check("rnd_in0_ready", in0_ready, win == 0);
    check("rnd_in1_ready", in1_ready, win == 1);
    @(posedge clk);
    #1;
    if (win >= 0) begin
      m_valid = 1;
      m_sel   = win;
      m_data  = (win == 1) ? d1 : d0;
      m_last  = win;
`ifdef GRANT_CNT_EN
      if (m_cnt[win] < CNT_MAX) m_cnt[win]++;
`endif
    end else if (ordy) begin
      m_valid = 0;
    end
    check("rnd_out_valid", out_valid, m_valid);
    if (m_valid != 0) begin
      check("rnd_out_sel", out_sel, m_sel);
      check("rnd_out_data", out_data, m_data);
    end
`ifdef GRANT_CNT_EN
    check("rnd_gnt_cnt0", gnt_cnt0, m_cnt[0]);
    check("rnd_gnt_cnt1", gnt_cnt1, m_cnt[1]);
`endif
  endtask

  initial begin
    //                 v0 v1 d0 d1 ordy  r0 r1  ev sel data
    vecs[0]  = mk(1, 1,  1,  2, 1,   1, 0,  1, 0,  1);
    vecs[1]  = mk(1, 1,  3,  4, 1,   0, 1,  1, 1,  4);
    vecs[2]  = mk(1, 1,  5,  6, 1,   1, 0,  1, 0,  5);
    vecs[3]  = mk(1, 1,  7,  8, 1,   0, 1,  1, 1,  8);
    vecs[4]  = mk(0, 1,  9,  1, 1,   0, 1,  1, 1,  1);
    vecs[5]  = mk(0, 1,  9,  1, 1,   0, 1,  1, 1,  1);
    vecs[6]  = mk(0, 1,  9,  1, 1,   0, 1,  1, 1,  1);
    vecs[7]  = mk(1, 1,  2,  3, 1,   1, 0,  1, 0,  2);
    vecs[8]  = mk(1, 1,  4,  5, 0,   0, 0,  1, 0,  2);
    vecs[9]  = mk(1, 1,  6,  7, 0,   0, 0,  1, 0,  2);
    vecs[10] = mk(1, 1,  8,  9, 0,   0, 0,  1, 0,  2);
    vecs[11] = mk(1, 1, 10, 11, 0,   0, 0,  1, 0,  2);
    vecs[12] = mk(1, 1, 12, 13, 0,   0, 0,  1, 0,  2);
    vecs[13] = mk(1, 0,  6,  0, 1,   1, 0,  1, 0,  6);
    vecs[14] = mk(1, 0,  7,  0, 1,   1, 0,  1, 0,  7);
    vecs[15] = mk(0, 0,  0,  0, 1,   0, 0,  0, 0,  0);
    vecs[16] = mk(0, 0,  0,  0, 0,   0, 0,  0, 0,  0);
    vecs[17] = mk(0, 1,  0, 12, 0,   0, 1,  1, 1, 12);

    do_reset();
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_sel", out_sel, 0);
`ifdef GRANT_CNT_EN
    check("reset_gnt_cnt0", gnt_cnt0, 0);
    check("reset_gnt_cnt1", gnt_cnt1, 0);
`endif

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].v0, vecs[i].v1, vecs[i].d0, vecs[i].d1, vecs[i].ordy);
      #1;
      check($sformatf("vec%0d_in0_ready", i), in0_ready, vecs[i].er0);
      check($sformatf("vec%0d_in1_ready", i), in1_ready, vecs[i].er1);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].ev);
      if (vecs[i].ev) begin
        check($sformatf("vec%0d_out_sel", i), out_sel, vecs[i].esel);
        check($sformatf("vec%0d_out_data", i), out_data, vecs[i].edata);
      end
    end

    // Asynchronous reset mid-cycle while a beat is held.
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_out_data", out_data, 0);
    check("async_rst_out_sel", out_sel, 0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 4'd3, 4'd9, 1'b1);
    #1;
    check("post_rst_tie_in0_ready", in0_ready, 1);
    check("post_rst_tie_in1_ready", in1_ready, 0);
    @(posedge clk);
    #1;
    check("post_rst_tie_out_sel", out_sel, 0);
    check("post_rst_tie_out_data", out_data, 3);

`ifdef GRANT_CNT_EN
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, DW'(i), '0, 1'b1);
      @(posedge clk);
      #1;
      check($sformatf("cnt_seq%0d_gnt_cnt0", i), gnt_cnt0, (i < 3) ? i + 1 : 3);
      check($sformatf("cnt_seq%0d_gnt_cnt1", i), gnt_cnt1, 0);
    end
    m_cnt[0] = 3;
    m_cnt[1] = 0;
`else
    m_cnt[0] = 0;
    m_cnt[1] = 0;
`endif

    // Model starts from a known state: fresh reset.
    do_reset();
    m_valid = 0; m_sel = 0; m_data = 0; m_last = 1;
    m_cnt[0] = 0; m_cnt[1] = 0;
    for (int i = 0; i < 400; i++) begin
      rand_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
